tdl_tdc_controller: RTL and testbench
=====================================

Name: tdl_tdc_controller

Overview:
Measurement sequencer for the N-tap carry-chain delay line and its capture flops. It clears and arms the chain, detects the hit in the registered tap snapshot, and freezes the snapshot. It then converts the thermometer code to a fine bin count and pairs it with a free-running coarse counter. The result is presented on a valid/ready timestamp port, in single-shot or continuous mode.

Parameters:
N, 32, number of delay taps; must match the chain width.
COARSE_W, 16, coarse counter width in clk cycles.
FINE_W, 6, fine code width; must be at least clog2(N+1).
TIMEOUT, 1024, maximum ARMED cycles before a no-hit result is reported; must be ≥1.

Ports:
clk  in  1  single system clock; chain capture flops share it.
clear  in  1  synchronous active-high reset.
arm  in  1  start-measurement pulse; sampled only in IDLE.
abort  in  1  cancel measurement; return to IDLE.
cfg_continuous  in  1  1 = re-arm automatically after each handshake.
chain_regout  in  N  registered tap snapshot from the chain.
chain_enable  out  1  capture-flop enable to the chain.
chain_clear  out  1  synchronous clear to the chain flops.
busy  out  1  high in every state except IDLE.
ts_valid  out  1  timestamp valid.
ts_ready  in  1  consumer ready.
ts_coarse  out  COARSE_W  coarse count at capture.
ts_fine  out  FINE_W  ones-count of captured code.
ts_timeout  out  1  no hit seen within TIMEOUT cycles.
ts_bubble  out  1  captured code not a clean thermometer.
ts_saturated  out  1  all N taps set (chain_regout[N-1]=1).

Behaviour:
- Reset (clear=1): state IDLE. coarse_cnt=0, timeout_cnt=0. All ts_* outputs 0, busy=0, chain_enable=0.
- chain_clear = clear OR (state==CLR), so the chain is wiped during reset.
- coarse_cnt: increments every cycle outside reset; wraps 2^COARSE_W-1 -> 0 silently.
- States: IDLE, CLR, ARMED, ENCODE, DONE.
- IDLE:
  - chain_enable=0.
  - arm=1 -> CLR.
- CLR (exactly 1 cycle):
  - chain_enable=1, chain_clear=1.
  - timeout_cnt<=0.
  - -> ARMED.
- ARMED:
  - chain_enable=1.
  - If chain_regout[0]=1: latch code<=chain_regout and cap_coarse<=coarse_cnt in the same cycle; -> ENCODE.
  - Else if timeout_cnt==TIMEOUT-1: latch code<=0 and set timeout flag; -> ENCODE.
  - Else timeout_cnt++.
  - A hit and the timeout in the same cycle: hit wins.
- ENCODE (1 cycle):
  - chain_enable=0, freezing the chain.
  - Register ts_fine=popcount(code).
  - ts_bubble=1 iff code is not of the form 0..01..1 (ones contiguous from bit 0).
  - ts_saturated=code[N-1].
  - ts_timeout=flag; ts_coarse=cap_coarse.
  - -> DONE.
- DONE:
  - ts_valid=1; all ts_* held stable until ts_valid&ts_ready.
  - On handshake: ts_valid<=0 next cycle. cfg_continuous=1 -> CLR, else IDLE.
- Latency: the hit-sample cycle T (regout[0]=1 in ARMED) gives ts_valid high at T+2.
- No-hit latency: CLR at cycle C gives ts_valid at C+TIMEOUT+2.
- abort=1 in any non-IDLE state:
  - Next state IDLE; ts_valid<=0; no result emitted.
  - abort has priority over a hit, a timeout and a handshake in the same cycle.
- arm outside IDLE is ignored; no queuing.
- cfg_continuous is sampled only at the DONE handshake.
- clear mid-operation behaves identically to reset. Any pending timestamp is discarded.
- ts_* fields are not cleared on handshake; only ts_valid qualifies them.
- Bins: ts_fine ranges 0..N. ts_fine=0 occurs only with ts_timeout=1.

Decomposition:
- Shared package tdc_pkg: state enum (IDLE, CLR, ARMED, ENCODE, DONE) and constant defaults N_TAPS=32 and COARSE_W=16.
- tdc_pkg also holds a clog2-based FINE_W helper, so that the chain, this controller and downstream histogram/calibration blocks agree on widths.
- One sub-module: tdl_thermo_encoder. Combinational popcount plus bubble/saturation detect on an N-bit code; instantiated inside ENCODE.

Test Plan:
- Single shot (N=32): arm pulse; snapshot 0x0000_00FF first appears 5 cycles after CLR -> ts_valid at that cycle +2. ts_fine=8, ts_coarse=coarse value at the sample cycle, bubble=0, saturated=0, timeout=0.
- Bubble and saturation: snapshot 0x0000_00F7 -> ts_fine=7, ts_bubble=1. Snapshot 0xFFFF_FFFF -> ts_fine=32, ts_saturated=1.
- Timeout (TIMEOUT=16): arm; snapshot stays 0 -> ts_valid exactly 18 cycles after CLR; ts_timeout=1, ts_fine=0.
- Backpressure and continuous mode: ts_ready=0 for 10 cycles -> outputs stable, chain_enable=0. Then ts_ready=1 with cfg_continuous=1 -> CLR next cycle (chain_clear pulse), ARMED after it.
- Abort and clear priority: abort asserted in the same cycle as a hit -> IDLE, no ts_valid. clear in DONE -> ts_valid=0, busy=0, chain_clear=1 while clear is held.
- Coarse wrap (COARSE_W=4): hit sampled when coarse_cnt=15 -> ts_coarse=15; the next measurement shows coarse_cnt wrapped through 0.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and width defaults for the tapped-delay-line TDC: the chain, the controller,
// and the downstream histogram and calibration blocks all size their buses from this package.
package tdc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StArmed,
    StEncode,
    StDone
  } state_e;

  localparam int unsigned N_TAPS   = 32;
  localparam int unsigned COARSE_W = 16;

  // The fine code must hold every ones-count from 0 to n inclusive.
  function automatic int unsigned fine_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tdl_thermo_encoder.sv
// Combinational thermometer-code analysis. It produces the ones-count of the code, flags a
// code that is not a clean run of ones from bit 0, and flags a fully saturated chain.
module tdl_thermo_encoder #(
  parameter int unsigned N      = 32,
  parameter int unsigned FINE_W = 6
) (
  input  logic [N-1:0]      code_i,
  output logic [FINE_W-1:0] fine_o,
  output logic              bubble_o,
  output logic              saturated_o
);

  localparam logic [N-1:0] One = N'(1);

  logic [N-1:0] plus1;

  always_comb begin
    fine_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      fine_o = fine_o + FINE_W'(code_i[i]);
    end
  end

  // Adding one to a clean thermometer code clears every set bit, so the AND is zero.
  assign plus1       = code_i + One;
  assign bubble_o    = |(code_i & plus1);
  assign saturated_o = code_i[N-1];

endmodule

// File: rtl/tdl_tdc_controller.sv
// Measurement sequencer for the carry-chain TDC. It clears and arms the chain, captures the
// first hit or a timeout, encodes the frozen snapshot, and holds the timestamp until it is taken.
module tdl_tdc_controller
  import tdc_pkg::*;
#(
  parameter int unsigned N        = tdc_pkg::N_TAPS,
  parameter int unsigned COARSE_W = tdc_pkg::COARSE_W,
  parameter int unsigned FINE_W   = tdc_pkg::fine_w(N),
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                arm,
  input  logic                abort,
  input  logic                cfg_continuous,
  input  logic [N-1:0]        chain_regout,
  output logic                chain_enable,
  output logic                chain_clear,
  output logic                busy,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                ts_timeout,
  output logic                ts_bubble,
  output logic                ts_saturated
);

  localparam int unsigned  TcW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TcW-1:0] TcLast = TcW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [COARSE_W-1:0] coarse_q;
  logic [COARSE_W-1:0] cap_coarse_q, cap_coarse_d;
  logic [TcW-1:0]      tcnt_q, tcnt_d;
  logic [N-1:0]        code_q, code_d;
  logic                to_flag_q, to_flag_d;

  logic [FINE_W-1:0]   enc_fine;
  logic                enc_bubble;
  logic                enc_sat;

  tdl_thermo_encoder #(
    .N      (N),
    .FINE_W (FINE_W)
  ) u_enc (
    .code_i      (code_q),
    .fine_o      (enc_fine),
    .bubble_o    (enc_bubble),
    .saturated_o (enc_sat)
  );

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    code_d       = code_q;
    cap_coarse_d = cap_coarse_q;
    to_flag_d    = to_flag_q;
    case (state_q)
      StIdle: begin
        if (arm) state_d = StClr;
      end
      StClr: begin
        tcnt_d    = '0;
        to_flag_d = 1'b0;
        state_d   = StArmed;
      end
      StArmed: begin
        // A hit in the same cycle as the last timeout count still counts as a hit.
        if (chain_regout[0]) begin
          code_d       = chain_regout;
          cap_coarse_d = coarse_q;
          to_flag_d    = 1'b0;
          state_d      = StEncode;
        end else if (tcnt_q == TcLast) begin
          code_d       = '0;
          cap_coarse_d = coarse_q;
          to_flag_d    = 1'b1;
          state_d      = StEncode;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StEncode: begin
        state_d = StDone;
      end
      StDone: begin
        if (ts_ready) state_d = cfg_continuous ? StClr : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= StIdle;
      coarse_q     <= '0;
      cap_coarse_q <= '0;
      tcnt_q       <= '0;
      code_q       <= '0;
      to_flag_q    <= 1'b0;
      ts_coarse    <= '0;
      ts_fine      <= '0;
      ts_timeout   <= 1'b0;
      ts_bubble    <= 1'b0;
      ts_saturated <= 1'b0;
    end else begin
      state_q      <= state_d;
      coarse_q     <= coarse_q + 1'b1;
      cap_coarse_q <= cap_coarse_d;
      tcnt_q       <= tcnt_d;
      code_q       <= code_d;
      to_flag_q    <= to_flag_d;
      if (state_q == StEncode) begin
        ts_coarse    <= cap_coarse_q;
        ts_fine      <= enc_fine;
        ts_timeout   <= to_flag_q;
        ts_bubble    <= enc_bubble;
        ts_saturated <= enc_sat;
      end
    end
  end

  assign chain_clear  = clear | (state_q == StClr);
  assign chain_enable = (state_q == StClr) | (state_q == StArmed);
  assign busy         = (state_q != StIdle);
  assign ts_valid     = (state_q == StDone);

endmodule

// File: tb/tb_tdl_tdc_controller.sv
// Self-checking bench for tdl_tdc_controller with a small coarse counter and a short timeout.
module tb_tdl_tdc_controller;

  logic        clk = 1'b0;
  logic        clear, arm, abort, cfg_continuous, ts_ready;
  logic [31:0] chain_regout;
  logic        chain_enable, chain_clear, busy, ts_valid;
  logic [3:0]  ts_coarse;
  logic [5:0]  ts_fine;
  logic        ts_timeout, ts_bubble, ts_saturated;

  int errors = 0;
  int checks = 0;

  // The coarse count is the number of clock edges since reset was released, modulo 16.
  logic [3:0] ref_coarse;

  tdl_tdc_controller #(
    .N        (32),
    .COARSE_W (4),
    .FINE_W   (6),
    .TIMEOUT  (16)
  ) dut (
    .clk            (clk),
    .clear          (clear),
    .arm            (arm),
    .abort          (abort),
    .cfg_continuous (cfg_continuous),
    .chain_regout   (chain_regout),
    .chain_enable   (chain_enable),
    .chain_clear    (chain_clear),
    .busy           (busy),
    .ts_valid       (ts_valid),
    .ts_ready       (ts_ready),
    .ts_coarse      (ts_coarse),
    .ts_fine        (ts_fine),
    .ts_timeout     (ts_timeout),
    .ts_bubble      (ts_bubble),
    .ts_saturated   (ts_saturated)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ref_coarse <= clear ? 4'd0 : ref_coarse + 4'd1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int exp_fine(input logic [31:0] c);
    return $countones(c);
  endfunction

  function automatic logic exp_bubble(input logic [31:0] c);
    longint unsigned clean;
    clean = (64'd1 << $countones(c)) - 64'd1;
    return (64'(c) != clean);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1; arm = 1'b0; abort = 1'b0; cfg_continuous = 1'b0; ts_ready = 1'b0;
    chain_regout = '0;
    step(); step();
    clear = 1'b0;
  endtask

  // Arms from IDLE; the snapshot shows up 'delay' cycles after the CLR cycle.
  task automatic do_hit(input logic [31:0] code, input int unsigned delay,
                        output logic v_early, output logic v_on, output logic [3:0] cap);
    arm = 1'b1; step(); arm = 1'b0;
    step();
    repeat (delay - 1) step();
    chain_regout = code; cap = ref_coarse;
    step(); v_early = ts_valid; chain_regout = '0;
    step(); v_on = ts_valid;
  endtask

  task automatic handshake();
    ts_ready = 1'b1; step(); ts_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; arm = 1'b0; abort = 1'b0; cfg_continuous = 1'b0; ts_ready = 1'b0;
    chain_regout = '0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", ts_valid); end
    checks++; if (chain_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%0b want=0", chain_enable); end
    checks++; if (chain_clear !== 1'b1) begin errors++; $display("FAIL reset_chain_clear got=%0b want=1", chain_clear); end
    checks++;
    if ({ts_coarse, ts_fine, ts_timeout, ts_bubble, ts_saturated} !== 13'd0) begin
      errors++; $display("FAIL reset_fields got=%0h want=0", {ts_coarse, ts_fine, ts_timeout, ts_bubble, ts_saturated});
    end
    clear = 1'b0; step();
    checks++; if (chain_clear !== 1'b0) begin errors++; $display("FAIL idle_chain_clear got=%0b want=0", chain_clear); end
  endtask

  task automatic test_single_shot();
    logic ve, vo; logic [3:0] cap;
    do_reset();
    do_hit(32'h0000_00FF, 5, ve, vo, cap);
    checks++; if (ve !== 1'b0) begin errors++; $display("FAIL ss_early_valid got=%0b want=0", ve); end
    checks++; if (vo !== 1'b1) begin errors++; $display("FAIL ss_valid_t2 got=%0b want=1", vo); end
    checks++; if (ts_fine !== 6'd8) begin errors++; $display("FAIL ss_fine got=%0d want=8", ts_fine); end
    checks++; if (ts_coarse !== cap) begin errors++; $display("FAIL ss_coarse got=%0d want=%0d", ts_coarse, cap); end
    checks++;
    if ({ts_bubble, ts_saturated, ts_timeout} !== 3'b000) begin
      errors++; $display("FAIL ss_flags got=%03b want=000", {ts_bubble, ts_saturated, ts_timeout});
    end
    checks++; if (chain_enable !== 1'b0) begin errors++; $display("FAIL ss_frozen got=%0b want=0", chain_enable); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_busy got=%0b want=1", busy); end
    handshake();
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL ss_after_hs_valid got=%0b want=0", ts_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_after_hs_busy got=%0b want=0", busy); end
  endtask

  task automatic test_bubble_sat();
    logic ve, vo; logic [3:0] cap;
    do_reset();
    do_hit(32'h0000_00F7, 3, ve, vo, cap);
    checks++; if (vo !== 1'b1) begin errors++; $display("FAIL bub_valid got=%0b want=1", vo); end
    checks++; if (ts_fine !== 6'd7) begin errors++; $display("FAIL bub_fine got=%0d want=7", ts_fine); end
    checks++; if (ts_bubble !== 1'b1) begin errors++; $display("FAIL bub_flag got=%0b want=1", ts_bubble); end
    checks++; if (ts_saturated !== 1'b0) begin errors++; $display("FAIL bub_sat got=%0b want=0", ts_saturated); end
    handshake();
    do_hit(32'hFFFF_FFFF, 2, ve, vo, cap);
    checks++; if (ts_fine !== 6'd32) begin errors++; $display("FAIL sat_fine got=%0d want=32", ts_fine); end
    checks++; if (ts_saturated !== 1'b1) begin errors++; $display("FAIL sat_flag got=%0b want=1", ts_saturated); end
    checks++; if (ts_bubble !== 1'b0) begin errors++; $display("FAIL sat_bubble got=%0b want=0", ts_bubble); end
    handshake();
  endtask

  task automatic test_timeout();
    logic early = 1'b0;
    do_reset();
    arm = 1'b1; step(); arm = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (ts_valid) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL to_early_valid got=1 want=0"); end
    step();
    checks++; if (ts_valid !== 1'b1) begin errors++; $display("FAIL to_valid_c18 got=%0b want=1", ts_valid); end
    checks++; if (ts_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got=%0b want=1", ts_timeout); end
    checks++; if (ts_fine !== 6'd0) begin errors++; $display("FAIL to_fine got=%0d want=0", ts_fine); end
    handshake();
  endtask

  task automatic test_backpressure_continuous();
    logic ve, vo; logic [3:0] cap; int bad = 0;
    do_reset();
    do_hit(32'h0000_003F, 4, ve, vo, cap);
    checks++; if (vo !== 1'b1) begin errors++; $display("FAIL bp_valid got=%0b want=1", vo); end
    for (int i = 0; i < 10; i++) begin
      step();
      if (ts_valid !== 1'b1 || chain_enable !== 1'b0 || ts_fine !== 6'd6 || ts_coarse !== cap) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got=%0d bad cycles want=0", bad); end
    cfg_continuous = 1'b1; ts_ready = 1'b1;
    step();
    ts_ready = 1'b0; cfg_continuous = 1'b0;
    checks++; if (chain_clear !== 1'b1) begin errors++; $display("FAIL cont_clr got=%0b want=1", chain_clear); end
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL cont_valid got=%0b want=0", ts_valid); end
    checks++; if (ts_fine !== 6'd6) begin errors++; $display("FAIL cont_fields_kept got=%0d want=6", ts_fine); end
    step();
    checks++;
    if ({chain_clear, chain_enable, busy} !== 3'b011) begin
      errors++; $display("FAIL cont_armed got=%03b want=011", {chain_clear, chain_enable, busy});
    end
    abort = 1'b1; step(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_abort_busy got=%0b want=0", busy); end
  endtask

  task automatic test_abort();
    logic ve, vo; logic [3:0] cap; logic seen = 1'b0;
    do_reset();
    arm = 1'b1; step(); arm = 1'b0;
    step();
    arm = 1'b1; chain_regout = 32'h0000_00FF; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0; chain_regout = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_hit_busy got=%0b want=0", busy); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (ts_valid || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result got=1 want=0"); end
    do_hit(32'h0000_00FF, 1, ve, vo, cap);
    checks++; if (vo !== 1'b1) begin errors++; $display("FAIL abort_setup_valid got=%0b want=1", vo); end
    cfg_continuous = 1'b1; ts_ready = 1'b1; abort = 1'b1;
    step();
    cfg_continuous = 1'b0; ts_ready = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, chain_clear, ts_valid} !== 3'b000) begin
      errors++; $display("FAIL abort_done got=%03b want=000", {busy, chain_clear, ts_valid});
    end
  endtask

  task automatic test_clear_done();
    logic ve, vo; logic [3:0] cap;
    do_reset();
    do_hit(32'h0000_0001, 2, ve, vo, cap);
    checks++; if (vo !== 1'b1) begin errors++; $display("FAIL clr_setup_valid got=%0b want=1", vo); end
    clear = 1'b1; step();
    checks++;
    if ({ts_valid, busy, chain_clear} !== 3'b001) begin
      errors++; $display("FAIL clr_done got=%03b want=001", {ts_valid, busy, chain_clear});
    end
    step();
    checks++; if (chain_clear !== 1'b1) begin errors++; $display("FAIL clr_held got=%0b want=1", chain_clear); end
    clear = 1'b0; step();
    checks++;
    if ({chain_clear, busy, ts_valid} !== 3'b000) begin
      errors++; $display("FAIL clr_released got=%03b want=000", {chain_clear, busy, ts_valid});
    end
  endtask

  task automatic test_coarse_wrap();
    logic ve, vo; logic [3:0] cap;
    do_reset();
    arm = 1'b1; step(); arm = 1'b0;
    step();
    for (int i = 0; i < 15 && ref_coarse != 4'd15; i++) step();
    chain_regout = 32'h0000_0003;
    step(); chain_regout = '0;
    step();
    checks++; if (ts_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%0b want=1", ts_valid); end
    checks++; if (ts_coarse !== 4'd15) begin errors++; $display("FAIL wrap_coarse15 got=%0d want=15", ts_coarse); end
    handshake();
    do_hit(32'h0000_0007, 3, ve, vo, cap);
    checks++; if (ts_coarse !== cap) begin errors++; $display("FAIL wrap_next got=%0d want=%0d", ts_coarse, cap); end
    checks++; if (ts_fine !== 6'd3) begin errors++; $display("FAIL wrap_next_fine got=%0d want=3", ts_fine); end
    handshake();
  endtask

  task automatic test_random();
    logic ve, vo; logic [3:0] cap; logic [31:0] code; int unsigned k, mode;
    do_reset();
    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 2);
      k    = $urandom_range(1, 32);
      code = 32'((64'd1 << k) - 64'd1);
      if (mode == 1) code = $urandom | 32'd1;
      if (mode == 2) code = code ^ (32'd1 << $urandom_range(1, 31));
      do_hit(code, $urandom_range(1, 10), ve, vo, cap);
      checks++;
      if ({ve, vo} !== 2'b01) begin
        errors++; $display("FAIL rnd_latency code=%08h got=%02b want=01", code, {ve, vo});
      end
      checks++;
      if (32'(ts_fine) !== 32'(exp_fine(code))) begin
        errors++; $display("FAIL rnd_fine code=%08h got=%0d want=%0d", code, ts_fine, exp_fine(code));
      end
      checks++;
      if ({ts_bubble, ts_saturated, ts_timeout} !== {exp_bubble(code), code[31], 1'b0}) begin
        errors++; $display("FAIL rnd_flags code=%08h got=%03b want=%03b", code,
                           {ts_bubble, ts_saturated, ts_timeout}, {exp_bubble(code), code[31], 1'b0});
      end
      checks++;
      if (ts_coarse !== cap) begin
        errors++; $display("FAIL rnd_coarse code=%08h got=%0d want=%0d", code, ts_coarse, cap);
      end
      repeat ($urandom_range(0, 3)) step();
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_bubble_sat();
    test_timeout();
    test_backpressure_continuous();
    test_abort();
    test_clear_done();
    test_coarse_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
